imem_loader_encoder: RTL and testbench
======================================

# imem_loader_encoder

Program-load front end for the pipelined RV32I core: accepts instruction field bundles (opcode, registers, funct fields, full immediate) over a valid/ready stream. It encodes each bundle into a 32-bit RV32I word, inverting the field layout the decode stage extracts, and writes the word into instruction memory at consecutive word addresses. It holds the core in reset while loading and releases it when the requested count has been written.

## Interface
Parameters:
- HOLD_ON_RESET, 1, value of core_hold during and after reset (1 = core held until first load completes)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  begin a load session; sampled in IDLE and DONE only
- start_addr  in  ADDR_WIDTH  first word address, latched on start
- count  in  ADDR_WIDTH+1  instructions to load, 0..MEM_SIZE, latched on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_fmt  in  3  instr_fmt_e: R, I, S, B, J
- in_op  in  7  opcode_e
- in_rd, in_rs1, in_rs2  in  5 each  reg_addr_t
- in_funct3  in  3  funct3_e
- in_funct7  in  7  funct7_e
- in_imm  in  XLEN  signed immediate, byte offset for B/J
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_WIDTH  write word address
- imem_wdata  out  XLEN  encoded instruction
- core_hold  out  1  keep core in reset
- busy  out  1  session in progress
- done  out  1  session complete, level
- err  out  1  sticky encode error, cleared on start

## Operation
- FSM states: IDLE, LOAD, DONE. Reset enters IDLE.
- IDLE/DONE + start: latch start_addr into wr_ptr and count into remaining; clear err and done; go to LOAD. If count==0, go directly to DONE.
- LOAD: in_ready = (remaining != 0). On handshake, register imem_we=1, imem_addr=wr_ptr, imem_wdata=encode(bundle). Then wr_ptr <= wr_ptr+1 mod MEM_SIZE (511 wraps to 0), and remaining decrements. On the handshake that brings remaining to 0, go to DONE.
- start is ignored in LOAD. in_valid is ignored outside LOAD.
- Encoding:
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Error cases set err; the word is still written:
  - Range: in_imm does not fit signed 12 bits (I/S), 13 bits (B) or 21 bits (J).
  - Alignment: in_imm[0]=1 for B/J. Bit 0 is dropped.
  - Reserved fmt: the word is written as NOP 0x00000013.
- core_hold: 1 in LOAD. In DONE it is 0 from the cycle after the final imem_we. In IDLE after reset it equals HOLD_ON_RESET; in IDLE otherwise it is 0.
- busy = (state==LOAD). done = (state==DONE).

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, core_hold=HOLD_ON_RESET.
- Write latency is 1 cycle: a handshake at edge N produces imem_we high during cycle N+1.
- Throughput is 1 instruction per cycle. imem_we is deasserted on any cycle without a handshake.
- The last write and done assert together, in the cycle after the final handshake. core_hold falls one cycle later.
- Reset mid-LOAD aborts the session immediately. No further writes occur, and memory contents already written are retained.

## Structure
- Add to the shared types package:
  - instr_fmt_e (3-bit: FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_J)
  - NOP_INSTR = 32'h0000_0013
  - loader_state_e
- Reuse the existing field bit-range and immediate-bit localparams for placement.
- Sub-module instr_encoder: purely combinational, taking bundle + fmt and producing word + err flag. The FSM, counters and output registers live in the top level.

## Test plan
- start_addr=0, count=1, I: op=0x13, rd=1, rs1=0, f3=0, imm=5 -> imem_wdata=0x00500093 at addr 0; done next cycle; err=0.
- count=3, back-to-back bundles:
  - R add x3,x1,x2 -> 0x002081B3
  - S sw x2,8(x1) -> 0x0020A423
  - B beq x0,x0,-4 -> 0xFE000EE3
  - Expect consecutive addrs 0,1,2 with imem_we high for 3 cycles.
- start_addr=511, count=2, second bundle J jal x1,8 -> writes at 511 then 0; second word 0x008000EF.
- I with imm=2048, then B with imm=3 -> err set and sticky; words are still written; err clears on the next start.
- count=0 -> DONE next cycle; in_ready never high; no imem_we. Separately, reset asserted after 2 of 4 writes -> all outputs return to reset values; no third write.
- in_valid toggling 1,0,1 with count=2 -> exactly two writes, gaps mirrored on imem_we; start pulsed during LOAD has no effect.

Source files
------------

// File: rtl/imem_loader_encoder_pkg.sv
// imem_loader_encoder_pkg: shared RV32I types, field positions and loader constants
// Provides XLEN/ADDR_WIDTH/MEM_SIZE, instruction field enums, loader FSM states,
// NOP_INSTR and a signed-range helper used by the encoder.
package imem_loader_encoder_pkg;
  localparam int XLEN       = 32;
  localparam int ADDR_WIDTH = 9;
  localparam int MEM_SIZE   = 1 << ADDR_WIDTH;
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int IMM_I_BITS = 12;
  localparam int IMM_S_BITS = 12;
  localparam int IMM_B_BITS = 13;
  localparam int IMM_J_BITS = 21;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef logic [4:0] reg_addr_t;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_e;
  typedef enum logic [2:0] {
    F3_ADD_SUB, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND
  } funct3_e;
  typedef enum logic [6:0] {
    F7_BASE = 7'h00,
    F7_ALT  = 7'h20
  } funct7_e;
  typedef enum logic [2:0] {FMT_R = 3'd0, FMT_I, FMT_S, FMT_B, FMT_J} instr_fmt_e;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} loader_state_e;
  // True when v sign-extends cleanly from its low 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction
endpackage

// File: rtl/imem_loader_encoder_if.sv
// imem_loader_encoder_if: load-session control, bundle stream and imem write bus
// master: program source driving start/count and field bundles
// slave : the loader, answering with in_ready, imem writes and status
interface imem_loader_encoder_if;
  import imem_loader_encoder_pkg::*;
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  in_valid;
  logic                  in_ready;
  instr_fmt_e            in_fmt;
  opcode_e               in_op;
  reg_addr_t             in_rd;
  reg_addr_t             in_rs1;
  reg_addr_t             in_rs2;
  funct3_e               in_funct3;
  funct7_e               in_funct7;
  logic [XLEN-1:0]       in_imm;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [XLEN-1:0]       imem_wdata;
  logic                  core_hold;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (
    output start, start_addr, count, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, done, err
  );
  modport slave (
    input  start, start_addr, count, in_valid, in_fmt, in_op, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, done, err
  );
endinterface

// File: rtl/imem_loader_encoder_encoder.sv
// instr_encoder: packs an RV32I field bundle into a 32-bit instruction word
// In : fmt, op, rd, rs1, rs2, f3, f7, imm (byte offset for B/J)
// Out: word (NOP for reserved fmt), err (range, misalignment or reserved fmt)
module instr_encoder
  import imem_loader_encoder_pkg::*;
(
  input  instr_fmt_e      fmt,
  input  opcode_e         op,
  input  reg_addr_t       rd,
  input  reg_addr_t       rs1,
  input  reg_addr_t       rs2,
  input  funct3_e         f3,
  input  funct7_e         f7,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] word,
  output logic            err
);
  always_comb begin
    word = NOP_INSTR;
    err  = 1'b1;
    case (fmt)
      FMT_R: begin
        word = {f7, rs2, rs1, f3, rd, op};
        err  = 1'b0;
      end
      FMT_I: begin
        word = {imm[11:0], rs1, f3, rd, op};
        err  = !fits_signed(imm, IMM_I_BITS);
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        err  = !fits_signed(imm, IMM_S_BITS);
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        err  = !fits_signed(imm, IMM_B_BITS) || imm[0];
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        err  = !fits_signed(imm, IMM_J_BITS) || imm[0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/imem_loader_encoder.sv
// imem_loader_encoder: streams encoded RV32I words into imem and holds the core while loading
// clk, rst_n : clock, asynchronous active-low reset
// bus        : slave side of imem_loader_encoder_if (session control, bundle stream,
//              imem write strobe/addr/data, core_hold/busy/done/err status)
module imem_loader_encoder
  import imem_loader_encoder_pkg::*;
#(
  parameter bit HOLD_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst_n,
  imem_loader_encoder_if.slave bus
);
  loader_state_e         state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [XLEN-1:0]       enc_word;
  logic                  enc_err;
  logic                  hs;
  logic                  start_ok;
  instr_encoder u_enc (
    .fmt  (bus.in_fmt),
    .op   (bus.in_op),
    .rd   (bus.in_rd),
    .rs1  (bus.in_rs1),
    .rs2  (bus.in_rs2),
    .f3   (bus.in_funct3),
    .f7   (bus.in_funct7),
    .imm  (bus.in_imm),
    .word (enc_word),
    .err  (enc_err)
  );
  assign hs       = bus.in_valid && bus.in_ready;
  assign start_ok = bus.start && state != ST_LOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (start_ok) state_nxt = (bus.count == '0) ? ST_DONE : ST_LOAD;
    else if (hs && remaining == (ADDR_WIDTH+1)'(1)) state_nxt = ST_DONE;
  end
  // IDLE is only reachable through reset, so its hold level is the reset level.
  always_comb begin
    bus.in_ready  = state == ST_LOAD && remaining != '0;
    bus.busy      = state == ST_LOAD;
    bus.done      = state == ST_DONE;
    bus.core_hold = state == ST_LOAD || (state == ST_DONE && bus.imem_we) ||
                    (state == ST_IDLE && HOLD_ON_RESET);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      remaining      <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.imem_we <= hs;
      if (hs) begin
        bus.imem_addr  <= wr_ptr;
        bus.imem_wdata <= enc_word;
        wr_ptr         <= wr_ptr + ADDR_WIDTH'(1);
        remaining      <= remaining - (ADDR_WIDTH+1)'(1);
        if (enc_err) bus.err <= 1'b1;
      end
      if (start_ok) begin
        wr_ptr    <= bus.start_addr;
        remaining <= bus.count;
        bus.err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader_encoder.sv
// tb_imem_loader_encoder: directed self-checking bench for imem_loader_encoder
module tb_imem_loader_encoder;
  import imem_loader_encoder_pkg::*;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total;
  int   n_writes;
  imem_loader_encoder_if bus ();
  imem_loader_encoder #(.HOLD_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.imem_we === 1'b1) n_writes++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_b(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.in_fmt    = instr_fmt_e'(f);
    bus.in_op     = opcode_e'(op);
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = funct3_e'(f3);
    bus.in_funct7 = funct7_e'(f7);
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
  endtask
  task automatic do_start(input logic [8:0] a, input logic [9:0] c);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.count      = c;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    logic [5:0] flags;
    flags = {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err, bus.core_hold};
    total++;
    if (flags !== 6'b000001) $display("FAIL reset_flags: got %b want 000001", flags);
    else pass_cnt++;
    total++;
    if (bus.imem_addr !== 9'd0) $display("FAIL reset_addr: got %h want 0", bus.imem_addr);
    else pass_cnt++;
    total++;
    if (bus.imem_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", bus.imem_wdata);
    else pass_cnt++;
  endtask
  task automatic test_single;
    do_start(9'd0, 10'd1);
    total++;
    if ({bus.busy, bus.in_ready, bus.core_hold} !== 3'b111)
      $display("FAIL single_load_state: got %b want 111", {bus.busy, bus.in_ready, bus.core_hold});
    else pass_cnt++;
    set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 9'd0, 32'h0050_0093})
      $display("FAIL single_write: got we=%b addr=%h data=%h want 1/0/00500093",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    total++;
    if ({bus.done, bus.core_hold, bus.err, bus.busy} !== 4'b1100)
      $display("FAIL single_done: got %b want 1100", {bus.done, bus.core_hold, bus.err, bus.busy});
    else pass_cnt++;
    tick();
    total++;
    if ({bus.imem_we, bus.core_hold, bus.done} !== 3'b001)
      $display("FAIL single_release: got %b want 001", {bus.imem_we, bus.core_hold, bus.done});
    else pass_cnt++;
  endtask
  task automatic test_back_to_back;
    do_start(9'd0, 10'd3);
    set_b(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 9'd0, 32'h0020_81B3})
      $display("FAIL b2b_r: got we=%b addr=%h data=%h want 1/0/002081b3",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    set_b(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    tick();
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 9'd1, 32'h0020_A423})
      $display("FAIL b2b_s: got we=%b addr=%h data=%h want 1/1/0020a423",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    set_b(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done} !== {1'b1, 9'd2, 32'hFE00_0EE3, 1'b1})
      $display("FAIL b2b_b: got we=%b addr=%h data=%h done=%b want 1/2/fe000ee3/1",
               bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.done);
    else pass_cnt++;
    tick();
    total++;
    if (bus.imem_we !== 1'b0) $display("FAIL b2b_we_drop: got %b want 0", bus.imem_we);
    else pass_cnt++;
  endtask
  task automatic test_wrap;
    do_start(9'd511, 10'd2);
    set_b(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    total++;
    if ({bus.imem_addr, bus.imem_wdata} !== {9'd511, 32'h0020_81B3})
      $display("FAIL wrap_first: got addr=%h data=%h want 1ff/002081b3", bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    set_b(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {1'b1, 9'd0, 32'h0080_00EF})
      $display("FAIL wrap_jal: got we=%b addr=%h data=%h want 1/0/008000ef",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    tick();
  endtask
  task automatic test_errors;
    do_start(9'd0, 10'd3);
    set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    total++;
    if ({bus.err, bus.imem_we, bus.imem_wdata} !== {2'b11, 32'h8000_0093})
      $display("FAIL err_range: got err=%b we=%b data=%h want 1/1/80000093",
               bus.err, bus.imem_we, bus.imem_wdata);
    else pass_cnt++;
    set_b(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    tick();
    total++;
    if ({bus.err, bus.imem_we, bus.imem_wdata} !== {2'b11, 32'h0000_0163})
      $display("FAIL err_align: got err=%b we=%b data=%h want 1/1/00000163",
               bus.err, bus.imem_we, bus.imem_wdata);
    else pass_cnt++;
    set_b(3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.err, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== {2'b11, 9'd2, 32'h0000_0013})
      $display("FAIL err_fmt: got err=%b we=%b addr=%h data=%h want 1/1/2/00000013",
               bus.err, bus.imem_we, bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    tick();
    total++;
    if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b want 1", bus.err);
    else pass_cnt++;
  endtask
  task automatic test_count_zero;
    int w0;
    w0 = n_writes;
    bus.in_valid = 1'b1;
    do_start(9'd7, 10'd0);
    total++;
    if ({bus.done, bus.busy, bus.in_ready, bus.err, bus.core_hold} !== 5'b10000)
      $display("FAIL zero_done: got %b want 10000",
               {bus.done, bus.busy, bus.in_ready, bus.err, bus.core_hold});
    else pass_cnt++;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    total++;
    if (n_writes - w0 !== 0 || bus.in_ready !== 1'b0)
      $display("FAIL zero_no_write: got writes=%0d ready=%b want 0/0", n_writes - w0, bus.in_ready);
    else pass_cnt++;
  endtask
  task automatic test_gaps;
    int w0;
    w0 = n_writes;
    do_start(9'd0, 10'd2);
    set_b(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    tick();
    total++;
    if (bus.imem_we !== 1'b1) $display("FAIL gap_first: got we=%b want 1", bus.imem_we);
    else pass_cnt++;
    bus.in_valid   = 1'b0;
    bus.start      = 1'b1;
    bus.start_addr = 9'd100;
    bus.count      = 10'd7;
    tick();
    bus.start = 1'b0;
    total++;
    if ({bus.imem_we, bus.busy} !== 2'b01)
      $display("FAIL gap_idle: got we/busy=%b want 01", {bus.imem_we, bus.busy});
    else pass_cnt++;
    set_b(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    tick();
    bus.in_valid = 1'b0;
    total++;
    if ({bus.imem_we, bus.imem_addr, bus.done} !== {1'b1, 9'd1, 1'b1})
      $display("FAIL gap_second: got we=%b addr=%h done=%b want 1/1/1",
               bus.imem_we, bus.imem_addr, bus.done);
    else pass_cnt++;
    tick();
    total++;
    if (n_writes - w0 !== 2) $display("FAIL gap_count: got %0d want 2", n_writes - w0);
    else pass_cnt++;
  endtask
  task automatic test_reset_abort;
    int w0;
    w0 = n_writes;
    do_start(9'd0, 10'd4);
    set_b(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err, bus.core_hold,
         bus.imem_addr, bus.imem_wdata} !== {6'b000001, 9'd0, 32'd0})
      $display("FAIL abort_reset: got flags=%b addr=%h data=%h want 000001/0/0",
               {bus.in_ready, bus.imem_we, bus.busy, bus.done, bus.err, bus.core_hold},
               bus.imem_addr, bus.imem_wdata);
    else pass_cnt++;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    total++;
    if (n_writes - w0 !== 2 || bus.busy !== 1'b0)
      $display("FAIL abort_writes: got writes=%0d busy=%b want 2/0", n_writes - w0, bus.busy);
    else pass_cnt++;
  endtask
  initial begin
    pass_cnt = 0;
    total = 0;
    n_writes = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.count = '0;
    set_b(3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) tick();
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    test_single();
    test_back_to_back();
    test_wrap();
    test_errors();
    test_count_zero();
    test_gaps();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
